led_pwm_driver: RTL
===================

# led_pwm_driver

Output stage placed directly downstream of the LED register peripheral: it takes the 8-bit LED pattern and drives the board pins through a global PWM brightness control. It decodes its own control registers on the shared processor bus at offsets 0x8 and 0xC, alongside the LED register at 0x0 and 0x4. Its read data is zero unless it is selected, so the top level can OR it with the LED peripheral's read bus.

## Interface
- PRESC_W, 8: width of prescaler field and counter
- PWM_W, 8: PWM counter and duty width
- clk  in  1  system clock
- rst  in  1  reset: one clock; synchronous, active-high
- rd_en_i  in  1  bus read strobe
- wr_en_i  in  1  bus write strobe
- addr_i  in  32  bus address; only addr_i[3:0] is decoded
- data_i  in  32  bus write data
- data_o  out  32  bus read data, combinational, zero when not selected
- leds_i  in  8  LED pattern from the LED register stage
- leds_o  out  8  registered, PWM-gated pin drive

## Operation
- DUTY at offset 0x8: bits[7:0] hold the duty value; reset 0xFF.
- CTRL at offset 0xC:
  - bit0 EN, reset 1.
  - bits[15:8] PRESC, reset 0.
  - bits[23:16] BLINK, reset 0; only present with the Configuration macro.
  - All other bits read 0.
- Writes take effect when wr_en_i=1 and the offset matches; other offsets are ignored.
- Reads: data_o returns the register zero-extended when rd_en_i=1 and the offset matches, otherwise 32'b0.
- Prescaler:
  - presc_cnt increments every cycle.
  - When presc_cnt >= PRESC: tick=1 and presc_cnt goes to 0.
  - PRESC=0 gives a tick every cycle.
  - Lowering PRESC below the current count produces a tick on the next cycle.
- PWM counter:
  - pwm_cnt increments on each tick and wraps 255 to 0.
  - A period starts on the tick where pwm_cnt wraps to 0.
- Duty shadow:
  - duty_act loads DUTY at each period start; writes to DUTY mid-period never change the current period.
  - At reset duty_act = 0xFF.
- Gating, with g = EN & blink_on & (duty_act==0xFF | pwm_cnt < duty_act):
  - duty_act=0x00 gives always off.
  - duty_act=0xFF gives always on, a special case.
  - Any other N gives N of every 256 counts on.
- Output: leds_o <= leds_i & {8{g}}.
- EN=0:
  - presc_cnt and pwm_cnt are held at 0 and leds_o is driven to 0.
  - When EN returns to 1, counting restarts from pwm_cnt=0 and duty_act reloads on the first cycle.
- Without the blink feature, blink_on is constant 1.

## Timing
- Reset values: leds_o=0, data_o=0 (combinational), presc_cnt=0, pwm_cnt=0, blink_cnt=0, blink phase=on.
- Latency from leds_i to leds_o is 1 cycle.
- A register write is visible to a read and to the gating on the next cycle, except for the duty shadow.
- A DUTY write that coincides with a period-start tick loads the new value into duty_act in that same cycle.
- A simultaneous rd_en_i and wr_en_i to the same offset returns the old value.
- Asserting rst mid-period returns everything to its reset values on the next edge.
- PWM period length = 256 × (PRESC+1) cycles.

## Configuration
- LED_BLINK_EN defined:
  - CTRL[23:16] BLINK is implemented.
  - blink_cnt counts completed PWM periods.
  - When blink_cnt reaches BLINK-1, the blink phase toggles and blink_cnt clears.
  - BLINK=0 forces phase on and clears blink_cnt.
  - blink_on = phase.
- LED_BLINK_EN undefined:
  - Bits [23:16] read 0 and writes to them are ignored.
  - blink_on = 1 and no blink logic is built.

## Structure
- Shared package holds:
  - offsets LED_PWM_DUTY_OFS=4'h8 and LED_PWM_CTRL_OFS=4'hC;
  - CTRL field positions;
  - reset constants DUTY_RST=8'hFF and CTRL_RST=32'h1.
- One sub-module, led_pwm_timebase, holds the prescaler, PWM counter and period-start pulse. The register file and gating stay at top level.

## Test plan
- Reset, then read 0x8 and 0xC → 0x000000FF and 0x00000001; leds_o=0; read 0x0 → data_o=0.
- leds_i=0xA5 with default registers → leds_o=0xA5 one cycle later and constant.
- DUTY=0x40, PRESC=0, leds_i=0xFF → leds_o=0xFF for 64 cycles then 0x00 for 192, repeating every 256.
- DUTY written to 0x10 mid-period (0x40 active) → current period still 64 high; next period 16 high.
- CTRL EN=0 mid-period → leds_o=0 next cycle. Re-enable → high phase restarts at pwm_cnt=0.
- With LED_BLINK_EN, DUTY=0xFF, PRESC=0, BLINK=2 → leds_o toggles every 512 cycles; read CTRL → 0x00020001. Without the macro, the same write reads back 0x00000001.

Source files
------------

// File: rtl/led_pwm_driver_pkg.sv
// Shared register map, reset constants and CTRL layout for led_pwm_driver.
package led_pwm_driver_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LED_W  = 8;

    localparam logic [3:0] LED_PWM_DUTY_OFS = 4'h8;
    localparam logic [3:0] LED_PWM_CTRL_OFS = 4'hC;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_PRESC_LSB = 8;
    localparam int unsigned CTRL_BLINK_LSB = 16;

    localparam logic [7:0]  DUTY_RST = 8'hFF;
    localparam logic [31:0] CTRL_RST = 32'h1;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] blink;
        logic [7:0] presc;
        logic [6:0] rsvd_lo;
        logic       en;
    } ctrl_reg_t;

    // Assemble the CTRL read value; reserved bits always read 0.
    function automatic logic [31:0] ctrl_pack(input logic en, input logic [7:0] presc,
                                              input logic [7:0] blink);
        ctrl_reg_t r;
        r       = '0;
        r.en    = en;
        r.presc = presc;
        r.blink = blink;
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_driver_timebase.sv
// Prescaler, PWM counter and period-start pulses (led_pwm_timebase).
module led_pwm_timebase
    import led_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned PWM_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic [PWM_W-1:0]   pwm_cnt_o,
    output logic               wrap_c,
    output logic               start_c
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               run_q, run_d;
    logic               tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            run_q       <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            run_q       <= run_d;
        end
    end

    // >= rather than == so lowering PRESC below the count ticks immediately.
    always_comb begin
        tick        = en_i && (presc_cnt_q >= presc_i);
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d   = pwm_cnt_q;
        run_d       = en_i;
        if (!en_i) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
        end
        wrap_c  = tick && (pwm_cnt_q == '1);
        // First enabled cycle after a disable also starts a fresh period.
        start_c = wrap_c || (en_i && !run_q);
    end

    assign pwm_cnt_o = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED pin driver with global PWM brightness; DUTY at 0x8, CTRL at 0xC.
// Define LED_BLINK_EN to build the CTRL.BLINK period-based blinker.
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned PWM_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [7:0]  leds_i,
    output logic [7:0]  leds_o
);

    logic [PWM_W-1:0]   duty_q, duty_d;
    logic [PWM_W-1:0]   duty_act_q, duty_act_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               wrap_c, start_c;
    logic               duty_sel, ctrl_sel, duty_wr, ctrl_wr;
    logic               blink_on, gate;
    logic [7:0]         blink_rd;
    logic               unused_bits;

    assign unused_bits = ^{addr_i[31:4], data_i[31:16]};

    led_pwm_timebase #(
        .PRESC_W (PRESC_W),
        .PWM_W   (PWM_W)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_q),
        .presc_i   (presc_q),
        .pwm_cnt_o (pwm_cnt),
        .wrap_c    (wrap_c),
        .start_c   (start_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q     <= PWM_W'(DUTY_RST);
            duty_act_q <= PWM_W'(DUTY_RST);
            en_q       <= CTRL_RST[CTRL_EN_BIT];
            presc_q    <= PRESC_W'(CTRL_RST[CTRL_PRESC_LSB +: 8]);
            leds_q     <= '0;
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            leds_q     <= leds_d;
        end
    end

    always_comb begin
        duty_sel = (addr_i[3:0] == LED_PWM_DUTY_OFS);
        ctrl_sel = (addr_i[3:0] == LED_PWM_CTRL_OFS);
        duty_wr  = wr_en_i && duty_sel;
        ctrl_wr  = wr_en_i && ctrl_sel;
        duty_d   = duty_q;
        en_d     = en_q;
        presc_d  = presc_q;
        if (duty_wr) begin
            duty_d = data_i[PWM_W-1:0];
        end
        if (ctrl_wr) begin
            en_d    = data_i[CTRL_EN_BIT];
            presc_d = data_i[CTRL_PRESC_LSB +: PRESC_W];
        end
        // duty_d already carries a same-cycle DUTY write into the new period.
        duty_act_d = start_c ? duty_d : duty_act_q;
        gate   = en_q && blink_on && ((duty_act_q == '1) || (pwm_cnt < duty_act_q));
        leds_d = leds_i & {LED_W{gate}};
    end

`ifdef LED_BLINK_EN
    logic [7:0] blink_q, blink_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q     <= CTRL_RST[CTRL_BLINK_LSB +: 8];
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Counts completed PWM periods; toggles phase every BLINK periods.
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (ctrl_wr) begin
            blink_d = data_i[CTRL_BLINK_LSB +: 8];
        end
        if (blink_q == 8'd0) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (wrap_c) begin
            if (blink_cnt_q == (blink_q - 8'd1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    assign blink_on = phase_q;
    assign blink_rd = blink_q;
`else
    assign blink_on = 1'b1;
    assign blink_rd = 8'd0;
`endif

    // Read mux is zero when unselected so it can be OR-ed onto the shared bus.
    always_comb begin
        data_o = '0;
        if (rd_en_i && duty_sel) begin
            data_o = DATA_W'(duty_q);
        end else if (rd_en_i && ctrl_sel) begin
            data_o = ctrl_pack(en_q, 8'(presc_q), blink_rd);
        end
    end

    assign leds_o = leds_q;

endmodule
